// File: rtl/fc_pkg.sv
// fc_pkg: class/state encodings and the modular credit check
// shared by the transmit credit gate and its descriptor FIFO.
package fc_pkg;

    typedef enum logic [1:0] {
        FC_P   = 2'b00,
        FC_NP  = 2'b01,
        FC_CPL = 2'b10
    } fc_class_e;

    typedef enum logic [1:0] {
        ST_UNINIT   = 2'd0,
        ST_ACTIVE   = 2'd1,
        ST_INFINITE = 2'd2
    } fc_state_e;

    localparam int FC_NCLS = 3;

    // Half-range compare: (lim - (cons + req)) mod 2^w <= 2^(w-1).
    function automatic logic fc_cr_ok(
        input logic [31:0] i_lim,
        input logic [31:0] i_cons,
        input logic [31:0] i_req,
        input int          i_w
    );
        logic [31:0] w_mask;
        logic [31:0] w_diff;
        w_mask = (32'd1 << i_w) - 32'd1;
        w_diff = (i_lim - i_cons - i_req) & w_mask;
        return w_diff <= (32'd1 << (i_w - 1));
    endfunction

endpackage

// File: rtl/fc_desc_fifo.sv
// fc_desc_fifo: in-order descriptor FIFO {type, data_cr, tag}
// with occupancy count; head data reads as zero when empty.
module fc_desc_fifo
    import fc_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int W     = 22
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_wr,
    input  logic [W-1:0]             i_wdata,
    input  logic                     i_rd,
    output logic [W-1:0]             o_rdata,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] P_ONE = AW'(1);
    localparam logic [AW:0]   C_ONE = (AW+1)'(1);
    localparam logic [AW:0]   C_MAX = (AW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_cnt;
    logic          w_wr;
    logic          w_rd;

    assign o_full  = (r_cnt == C_MAX);
    assign o_empty = (r_cnt == '0);
    assign o_count = r_cnt;
    assign w_wr    = i_wr && !o_full;
    assign w_rd    = i_rd && !o_empty;
    assign o_rdata = o_empty ? '0 : r_mem[r_rptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + P_ONE;
            if (w_rd) r_rptr <= r_rptr + P_ONE;
            unique case ({w_wr, w_rd})
                2'b10:   r_cnt <= r_cnt + C_ONE;
                2'b01:   r_cnt <= r_cnt - C_ONE;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr] <= i_wdata;
    end

endmodule

// File: rtl/fc_tx_credit_gate.sv
// fc_tx_credit_gate: in-order TLP release gated by per-class credit.
// Optional FC_INFINITE_CREDIT_EN: InitFC field 0 means infinite credit.
module fc_tx_credit_gate
    import fc_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int HDR_W      = 8,
    parameter int DATA_W     = 12,
    parameter int TAG_W      = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [1:0]                 wr_type,
    input  logic [DATA_W-1:0]          wr_data_cr,
    input  logic [TAG_W-1:0]           wr_tag,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(FIFO_DEPTH):0] count,
    input  logic                       fc_valid,
    input  logic                       fc_init,
    input  logic [1:0]                 fc_type,
    input  logic [HDR_W-1:0]           fc_hdr,
    input  logic [DATA_W-1:0]          fc_data,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic [1:0]                 tx_type,
    output logic [DATA_W-1:0]          tx_data_cr,
    output logic [TAG_W-1:0]           tx_tag,
    output logic                       blocked,
    output logic [3*HDR_W-1:0]         cons_hdr,
    output logic [3*DATA_W-1:0]        cons_data
);

    localparam int EW = 2 + DATA_W + TAG_W;
    localparam logic [HDR_W-1:0] H_ONE = HDR_W'(1);

    logic          w_push;
    logic          w_xfer;
    logic [EW-1:0] w_head;
    logic [3:0]    w_cls_ok;

    assign w_push = wr_en && (wr_type != 2'b11);

    fc_desc_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_wr    (w_push),
        .i_wdata ({wr_type, wr_data_cr, wr_tag}),
        .i_rd    (w_xfer),
        .o_rdata (w_head),
        .o_count (count),
        .o_full  (full),
        .o_empty (empty)
    );

    assign {tx_type, tx_data_cr, tx_tag} = w_head;

    // Only registered state feeds the gate; tx_ready only drives the pop.
    assign w_cls_ok[3] = 1'b0;
    assign tx_valid    = !empty && w_cls_ok[tx_type];
    assign blocked     = !empty && !tx_valid;
    assign w_xfer      = tx_valid && tx_ready;

    for (genvar c = 0; c < FC_NCLS; c++) begin : g_cls
        fc_state_e         r_st;
        fc_state_e         w_st_nxt;
        logic [HDR_W-1:0]  r_lim_hdr;
        logic [DATA_W-1:0] r_lim_data;
        logic [HDR_W-1:0]  r_cons_hdr;
        logic [DATA_W-1:0] r_cons_data;
        logic              w_init;
        logic              w_upd;
        logic              w_sel;
        logic              w_hdr_inf;
        logic              w_data_inf;
        logic              w_hdr_ok;
        logic              w_data_ok;

        assign w_init = fc_valid && fc_init && (fc_type == 2'(c));
        assign w_upd  = fc_valid && !fc_init && (fc_type == 2'(c));
        assign w_sel  = w_xfer && (tx_type == 2'(c));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) r_st <= ST_UNINIT;
            else     r_st <= w_st_nxt;
        end

        always_comb begin
            w_st_nxt = r_st;
            unique case (r_st)
                ST_UNINIT: begin
                    if (w_init) w_st_nxt = ST_ACTIVE;
`ifdef FC_INFINITE_CREDIT_EN
                    if (w_init && fc_hdr == '0 && fc_data == '0)
                        w_st_nxt = ST_INFINITE;
`endif
                end
                default: w_st_nxt = r_st;
            endcase
        end

`ifdef FC_INFINITE_CREDIT_EN
        logic r_hdr_inf;
        logic r_data_inf;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_hdr_inf  <= 1'b0;
                r_data_inf <= 1'b0;
            end else if (w_init && r_st == ST_UNINIT) begin
                r_hdr_inf  <= (fc_hdr == '0);
                r_data_inf <= (fc_data == '0);
            end
        end

        assign w_hdr_inf  = r_hdr_inf;
        assign w_data_inf = r_data_inf;
`else
        assign w_hdr_inf  = 1'b0;
        assign w_data_inf = 1'b0;
`endif

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_lim_hdr  <= '0;
                r_lim_data <= '0;
            end else if (w_init && r_st == ST_UNINIT) begin
                r_lim_hdr  <= fc_hdr;
                r_lim_data <= fc_data;
            end else if (w_upd && r_st != ST_UNINIT) begin
                if (!w_hdr_inf)  r_lim_hdr  <= fc_hdr;
                if (!w_data_inf) r_lim_data <= fc_data;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_cons_hdr  <= '0;
                r_cons_data <= '0;
            end else if (w_sel) begin
                r_cons_hdr  <= r_cons_hdr + H_ONE;
                r_cons_data <= r_cons_data + tx_data_cr;
            end
        end

        assign w_hdr_ok = w_hdr_inf || (r_st == ST_INFINITE)
            || fc_cr_ok(32'(r_lim_hdr), 32'(r_cons_hdr), 32'd1, HDR_W);

        assign w_data_ok = w_data_inf || (r_st == ST_INFINITE)
            || (tx_data_cr == '0)
            || fc_cr_ok(32'(r_lim_data), 32'(r_cons_data),
                        32'(tx_data_cr), DATA_W);

        assign w_cls_ok[c] = (r_st != ST_UNINIT) && w_hdr_ok && w_data_ok;

        assign cons_hdr[c*HDR_W +: HDR_W]    = r_cons_hdr;
        assign cons_data[c*DATA_W +: DATA_W] = r_cons_data;
    end

endmodule

// File: tb/tb_fc_tx_credit_gate.sv
// tb_fc_tx_credit_gate: directed vectors for the credit gate,
// expectations hand-computed from modular credit arithmetic.
module tb_fc_tx_credit_gate;

    localparam int FIFO_DEPTH = 16;
    localparam int HDR_W      = 8;
    localparam int DATA_W     = 12;
    localparam int TAG_W      = 8;
    localparam logic [1:0] CP   = 2'd0;
    localparam logic [1:0] CNP  = 2'd1;
    localparam logic [1:0] CCPL = 2'd2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic wr_en = 1'b0;
    logic [1:0] wr_type = '0;
    logic [DATA_W-1:0] wr_data_cr = '0;
    logic [TAG_W-1:0] wr_tag = '0;
    logic full, empty;
    logic [$clog2(FIFO_DEPTH):0] count;
    logic fc_valid = 1'b0;
    logic fc_init = 1'b0;
    logic [1:0] fc_type = '0;
    logic [HDR_W-1:0] fc_hdr = '0;
    logic [DATA_W-1:0] fc_data = '0;
    logic tx_valid;
    logic tx_ready = 1'b0;
    logic [1:0] tx_type;
    logic [DATA_W-1:0] tx_data_cr;
    logic [TAG_W-1:0] tx_tag;
    logic blocked;
    logic [3*HDR_W-1:0] cons_hdr;
    logic [3*DATA_W-1:0] cons_data;

    int n_chk = 0;
    int n_fail = 0;
    int n_blk = 0;

    fc_tx_credit_gate #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .HDR_W      (HDR_W),
        .DATA_W     (DATA_W),
        .TAG_W      (TAG_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_type    (wr_type),
        .wr_data_cr (wr_data_cr),
        .wr_tag     (wr_tag),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .fc_valid   (fc_valid),
        .fc_init    (fc_init),
        .fc_type    (fc_type),
        .fc_hdr     (fc_hdr),
        .fc_data    (fc_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_type    (tx_type),
        .tx_data_cr (tx_data_cr),
        .tx_tag     (tx_tag),
        .blocked    (blocked),
        .cons_hdr   (cons_hdr),
        .cons_data  (cons_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] t, input logic [DATA_W-1:0] cr,
                        input logic [TAG_W-1:0] tg);
        wr_en = 1'b1; wr_type = t; wr_data_cr = cr; wr_tag = tg;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic fc(input logic ini, input logic [1:0] t,
                      input logic [HDR_W-1:0] h, input logic [DATA_W-1:0] d);
        fc_valid = 1'b1; fc_init = ini; fc_type = t;
        fc_hdr = h; fc_data = d;
        tick();
        fc_valid = 1'b0;
    endtask

    task automatic xfer();
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_txv", tx_valid, 0);
        chk("rst_blk", blocked, 0);
        chk("rst_ch", cons_hdr, 0);
        chk("rst_cd", cons_data, 0);
        chk("rst_txf", {tx_type, tx_data_cr, tx_tag}, 0);
        rst = 1'b0;
        tick();

        push(CP, 12'd4, 8'h11);
        chk("noinit_txv", tx_valid, 0);
        chk("noinit_blk", blocked, 1);
        chk("push_cnt", count, 1);
        chk("push_tag", tx_tag, 8'h11);
        fc(1'b1, CP, 8'd2, 12'd8);
        chk("init_txv", tx_valid, 1);
        chk("init_blk", blocked, 0);
        xfer();
        chk("p_ch1", cons_hdr[7:0], 1);
        chk("p_cd4", cons_data[11:0], 4);
        chk("p_empty", empty, 1);

        push(2'b11, 12'd1, 8'hEE);
        chk("illegal_drop", empty, 1);
        fc(1'b1, CP, 8'd0, 12'd0);
        push(CP, 12'd4, 8'h12);
        chk("reinit_ign", tx_valid, 1);
        xfer();
        chk("p_ch2", cons_hdr[7:0], 2);
        chk("p_cd8", cons_data[11:0], 8);

        fc(1'b1, CNP, 8'd1, 12'd8);
        push(CNP, 12'd4, 8'h21);
        push(CNP, 12'd4, 8'h22);
        chk("np_cnt2", count, 2);
        chk("np_first", tx_valid, 1);
        xfer();
        chk("np_head2", tx_tag, 8'h22);
        chk("np_hdr_blk", blocked, 1);
        chk("np_ch1", cons_hdr[15:8], 1);
        fc(1'b0, CNP, 8'd2, 12'd8);
        chk("np_upd_txv", tx_valid, 1);
        xfer();
        chk("np_ch2", cons_hdr[15:8], 2);
        chk("np_cd8", cons_data[23:12], 8);
        chk("np_empty", empty, 1);

        fc(1'b0, CNP, 8'd10, 12'd4094);
        push(CNP, 12'd4086, 8'h31);
        chk("np_big_txv", tx_valid, 1);
        xfer();
        chk("np_cd4094", cons_data[23:12], 4094);
        fc(1'b0, CNP, 8'd10, 12'd2);
        push(CNP, 12'd4, 8'h32);
        chk("wrap_txv", tx_valid, 1);
        xfer();
        chk("wrap_cd2", cons_data[23:12], 2);
        chk("wrap_ch4", cons_hdr[15:8], 4);
        push(CNP, 12'd1, 8'h33);
        chk("wrap_blk", blocked, 1);
        fc(1'b0, CNP, 8'd10, 12'd3);
        chk("wrap_upd", tx_valid, 1);
        xfer();
        chk("wrap_cd3", cons_data[23:12], 3);
        chk("p_untouched", cons_hdr[7:0], 2);

        for (int i = 0; i < 17; i++)
            push(CCPL, 12'(i), 8'(8'h40 + i));
        chk("full_cnt", count, 16);
        chk("full_flag", full, 1);
        chk("cpl_uninit", blocked, 1);
        fc(1'b1, CCPL, 8'd100, 12'd200);
        chk("cpl_init", tx_valid, 1);
        chk("drain_t0", tx_tag, 8'h40);
        wr_en = 1'b1; wr_type = CCPL; wr_data_cr = 12'd9; wr_tag = 8'h99;
        tx_ready = 1'b1;
        tick();
        wr_en = 1'b0;
        chk("full_pushpop", count, 15);
        chk("full_clear", full, 0);
        for (int i = 1; i < 16; i++) begin
            chk("drain_tag", tx_tag, 8'(8'h40 + i));
            chk("drain_txv", tx_valid, 1);
            tick();
        end
        tx_ready = 1'b0;
        chk("drain_empty", empty, 1);
        chk("cpl_ch16", cons_hdr[23:16], 16);
        chk("cpl_cd120", cons_data[35:24], 120);

        push(CCPL, 12'd1, 8'h77);
        wr_en = 1'b1; wr_type = CCPL; wr_data_cr = 12'd2; wr_tag = 8'h78;
        tx_ready = 1'b1;
        tick();
        wr_en = 1'b0;
        tx_ready = 1'b0;
        chk("pp_cnt", count, 1);
        chk("pp_tag", tx_tag, 8'h78);
        xfer();
        chk("pp_ch", cons_hdr[23:16], 18);
        chk("pp_cd", cons_data[35:24], 123);

        fc(1'b0, CP, 8'd100, 12'd200);
        for (int i = 0; i < 16; i++)
            push(CP, 12'd0, 8'(8'h50 + i));
        chk("rf_full", full, 1);
        chk("rf_txv", tx_valid, 1);
        tx_ready = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("ar_cnt", count, 0);
        chk("ar_empty", empty, 1);
        chk("ar_txv", tx_valid, 0);
        chk("ar_blk", blocked, 0);
        chk("ar_ch", cons_hdr, 0);
        chk("ar_cd", cons_data, 0);
        chk("ar_tag", tx_tag, 0);
        tick();
        rst = 1'b0;
        tx_ready = 1'b0;
        tick();
        push(CP, 12'd0, 8'h61);
        chk("ar_uninit", blocked, 1);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        fc(1'b1, CCPL, 8'd0, 12'd0);
        push(CCPL, 12'd3, 8'h70);
`ifdef FC_INFINITE_CREDIT_EN
        chk("inf_txv", tx_valid, 1);
        wr_en = 1'b1; wr_type = CCPL; wr_data_cr = 12'd3; wr_tag = 8'h70;
        tx_ready = 1'b1;
        for (int i = 0; i < 99; i++) begin
            if (blocked) n_blk++;
            tick();
        end
        wr_en = 1'b0;
        if (blocked) n_blk++;
        tick();
        tx_ready = 1'b0;
        chk("inf_noblk", n_blk, 0);
        chk("inf_empty", empty, 1);
        chk("inf_ch", cons_hdr[23:16], 100);
        chk("inf_cd", cons_data[35:24], 300);
        fc(1'b0, CCPL, 8'd1, 12'd1);
        push(CCPL, 12'd3, 8'h71);
        chk("inf_upd_ign", tx_valid, 1);
`else
        chk("zero_txv", tx_valid, 0);
        chk("zero_blk", blocked, 1);
        fc(1'b0, CCPL, 8'd1, 12'd8);
        chk("zero_upd", tx_valid, 1);
        xfer();
        chk("zero_ch", cons_hdr[23:16], 1);
        chk("zero_cd", cons_data[35:24], 3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
